// File: rtl/mac_acc_reader.sv
// Snapshots the accumulator and streams it out LSB chunk first over valid/ready.
// Optionally strobes the accumulator clear afterwards, holding loads meanwhile.
module mac_acc_reader #(
  parameter int ACC_W = 16,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_req,
  input  logic             clr_on_read,
  input  logic [ACC_W-1:0] acc_q,
  output logic             acc_hold,
  output logic             acc_clr,
  output logic             busy,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready
);

  localparam int NCHUNK = ACC_W / OUT_W;
  localparam int CNT_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    CLEAR
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] shadow;
  logic [ACC_W-1:0] shadow_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             clr_lat;

  assign shadow_nx = shadow >> OUT_W;
  assign cnt_nx    = cnt + CNT_W'(1);
  assign out_data  = shadow[OUT_W-1:0];

  // Hold must already be up on the capture edge so no load slips in.
  assign acc_hold = rst_n &&
    ((state == IDLE && rd_req && clr_on_read) || (busy && clr_lat));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shadow    <= '0;
      cnt       <= '0;
      clr_lat   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      acc_clr   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rd_req) begin
            shadow    <= acc_q;
            clr_lat   <= clr_on_read;
            cnt       <= '0;
            out_valid <= 1'b1;
            out_last  <= (NCHUNK == 1);
            busy      <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            shadow <= shadow_nx;
            cnt    <= cnt_nx;
            if (cnt == LAST_CNT) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              if (clr_lat) begin
                acc_clr <= 1'b1;
                state   <= CLEAR;
              end else begin
                busy  <= 1'b0;
                state <= IDLE;
              end
            end else begin
              out_last <= (cnt_nx == LAST_CNT);
            end
          end
        end
        CLEAR: begin
          acc_clr <= 1'b0;
          busy    <= 1'b0;
          clr_lat <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
